// File: rtl/ushift_pkg.sv
// Shared mode encodings for the universal shift register and its testbench.
package ushift_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_RSVD = 3'b111;

    // True for every mode that moves one bit out of the register.
    function automatic logic is_shift_mode(input logic [2:0] m);
        return (m >= MODE_SHL) && (m <= MODE_ASR);
    endfunction

endpackage

// File: rtl/ushift_counter.sv
// Saturating shift counter with a single "word shifted out" strobe.
module ushift_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_cnt,
    input  logic             inc,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             shift_done
);

    localparam logic [CNT_W-1:0] CntMax  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             done_q;

    // Count shifts up to WIDTH; pulse only on the transition into saturation.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (inc && (cnt_q != CntMax)) begin
            cnt_q  <= cnt_q + 1'b1;
            done_q <= (cnt_q == CntLast);
        end else begin
            done_q <= 1'b0;
        end
    end

    assign shift_cnt  = cnt_q;
    assign shift_done = done_q;

endmodule

// File: rtl/univ_shift_loadclearreg.sv
// Universal register: load, clear, shift/rotate both ways, arithmetic shift right,
// serial in/out and a saturating shift counter.
// Optional feature macro: USHIFT_PARITY_EN adds a registered parity_out of Qout.
module univ_shift_loadclearreg
    import ushift_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             ser_in,
    output logic [WIDTH-1:0] Qout,
    output logic             ser_out,
`ifdef USHIFT_PARITY_EN
    output logic             parity_out,
`endif
    output logic [CNT_W-1:0] shift_cnt,
    output logic             shift_done
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             so_q, so_d;
    logic             do_shift;
    logic             clr_cnt;

    // Next-state mux for the data register and the serial-out bit.
    always_comb begin
        q_d  = q_q;
        so_d = so_q;
        case (mode)
            MODE_LOAD: q_d = D;
            MODE_SHL: begin
                q_d  = {q_q[WIDTH-2:0], ser_in};
                so_d = q_q[WIDTH-1];
            end
            MODE_SHR: begin
                q_d  = {ser_in, q_q[WIDTH-1:1]};
                so_d = q_q[0];
            end
            MODE_ROL: begin
                q_d  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                so_d = q_q[WIDTH-1];
            end
            MODE_ROR: begin
                q_d  = {q_q[0], q_q[WIDTH-1:1]};
                so_d = q_q[0];
            end
            MODE_ASR: begin
                q_d  = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                so_d = q_q[0];
            end
            default: ;
        endcase
    end

    // Data and serial-out registers; reset and clear both zero them.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            q_q  <= '0;
            so_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            so_q <= so_d;
        end
    end

    assign Qout    = q_q;
    assign ser_out = so_q;

`ifdef USHIFT_PARITY_EN
    logic par_q;

    // Parity of the value being loaded into Qout, so it always tracks Qout.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            par_q <= 1'b0;
        end else begin
            par_q <= ^q_d;
        end
    end

    assign parity_out = par_q;
`endif

    // Clear and LOAD both restart the shift count; clear also masks the shift.
    assign do_shift = is_shift_mode(mode) && !clear;
    assign clr_cnt  = clear || (mode == MODE_LOAD);

    ushift_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .clr_cnt    (clr_cnt),
        .inc        (do_shift),
        .shift_cnt  (shift_cnt),
        .shift_done (shift_done)
    );

endmodule

// File: tb/tb_univ_shift_loadclearreg.sv
// Directed self-checking bench for univ_shift_loadclearreg (WIDTH = 8).
// Build with USHIFT_PARITY_EN defined to also exercise parity_out.
module tb_univ_shift_loadclearreg;
    import ushift_pkg::*;

    localparam int unsigned W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic [2:0] mode;
    logic [7:0] d;
    logic       ser_in;
    logic [7:0] qout;
    logic       ser_out;
    logic [3:0] shift_cnt;
    logic       shift_done;
`ifdef USHIFT_PARITY_EN
    logic       parity_out;
`endif

    int checks = 0;
    int errors = 0;

    univ_shift_loadclearreg #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .mode       (mode),
        .D          (d),
        .ser_in     (ser_in),
        .Qout       (qout),
        .ser_out    (ser_out),
`ifdef USHIFT_PARITY_EN
        .parity_out (parity_out),
`endif
        .shift_cnt  (shift_cnt),
        .shift_done (shift_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic [2:0] m, input logic [7:0] dv, input logic si);
        mode   = m;
        d      = dv;
        ser_in = si;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_so;
        rst = 1'b1; clear = 1'b0; mode = MODE_LOAD; d = 8'hA5; ser_in = 1'b0;
        #1;

        // 1. Reset with LOAD pending must win.
        step(MODE_LOAD, 8'hA5, 1'b0);
        step(MODE_LOAD, 8'hA5, 1'b0);
        check("rst_q", qout, 8'h00);
        check("rst_so", ser_out, 1'b0);
        check("rst_cnt", shift_cnt, 4'd0);
        check("rst_done", shift_done, 1'b0);
        rst = 1'b0;

        // 2. LOAD B4, 8x SHL with ser_in=1.
        step(MODE_LOAD, 8'hB4, 1'b0);
        check("ld_b4", qout, 8'hB4);
        check("ld_cnt", shift_cnt, 4'd0);
        exp_so = 8'b1011_0100;
        for (int i = 0; i < 8; i++) begin
            step(MODE_SHL, 8'h00, 1'b1);
            check($sformatf("shl_so%0d", i), ser_out, exp_so[7-i]);
            check($sformatf("shl_done%0d", i), shift_done, (i == 7) ? 1'b1 : 1'b0);
        end
        check("shl_q", qout, 8'hFF);
        check("shl_cnt", shift_cnt, 4'd8);
        // Saturated: another shift must not pulse again, count stays at WIDTH.
        step(MODE_SHL, 8'h00, 1'b0);
        check("sat_done", shift_done, 1'b0);
        check("sat_cnt", shift_cnt, 4'd8);
        check("sat_q", qout, 8'hFE);
        // HOLD and reserved keep everything.
        step(MODE_HOLD, 8'h55, 1'b1);
        check("hold_q", qout, 8'hFE);
        step(MODE_RSVD, 8'h55, 1'b1);
        check("rsvd_q", qout, 8'hFE);
        check("rsvd_cnt", shift_cnt, 4'd8);

        // 3. LOAD 81 (re-arms counter), ROR, ROL x2.
        step(MODE_LOAD, 8'h81, 1'b0);
        check("rearm_cnt", shift_cnt, 4'd0);
        step(MODE_ROR, 8'h00, 1'b0);
        check("ror_q", qout, 8'hC0);
        check("ror_so", ser_out, 1'b1);
        step(MODE_ROL, 8'h00, 1'b0);
        check("rol1_q", qout, 8'h81);
        step(MODE_ROL, 8'h00, 1'b0);
        check("rol2_q", qout, 8'h03);
        check("rol2_so", ser_out, 1'b1);  // bit 7 of 81 leaves on the 2nd ROL

        // 4. LOAD 80, ASR x3.
        step(MODE_LOAD, 8'h80, 1'b0);
        for (int i = 0; i < 3; i++) step(MODE_ASR, 8'h00, 1'b1);
        check("asr_q", qout, 8'hF0);
        check("asr_cnt", shift_cnt, 4'd3);
        check("asr_done", shift_done, 1'b0);
        check("asr_so", ser_out, 1'b0);

        // 5. LOAD 0F, 5x SHR, clear with SHL pending, 8x SHR.
        step(MODE_LOAD, 8'h0F, 1'b0);
        for (int i = 0; i < 5; i++) step(MODE_SHR, 8'h00, 1'b0);
        check("shr5_q", qout, 8'h00);
        check("shr5_cnt", shift_cnt, 4'd5);
        check("shr5_so", ser_out, 1'b0);
        clear = 1'b1;
        step(MODE_SHL, 8'h00, 1'b1);
        clear = 1'b0;
        check("clr_q", qout, 8'h00);
        check("clr_so", ser_out, 1'b0);
        check("clr_cnt", shift_cnt, 4'd0);
        check("clr_done", shift_done, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(MODE_SHR, 8'h00, 1'b1);
            check($sformatf("shr_done%0d", i), shift_done, (i == 7) ? 1'b1 : 1'b0);
        end
        check("shr8_q", qout, 8'hFF);
        check("shr8_cnt", shift_cnt, 4'd8);
        step(MODE_HOLD, 8'h00, 1'b0);
        check("pulse_end", shift_done, 1'b0);

`ifdef USHIFT_PARITY_EN
        // 6. Parity tracks Qout.
        step(MODE_LOAD, 8'h07, 1'b0);
        check("par_ld", parity_out, 1'b1);
        step(MODE_SHL, 8'h00, 1'b0);
        check("par_shl_q", qout, 8'h0E);
        check("par_shl", parity_out, 1'b1);
        step(MODE_LOAD, 8'h03, 1'b0);
        check("par_even", parity_out, 1'b0);
        clear = 1'b1;
        step(MODE_LOAD, 8'h01, 1'b0);
        clear = 1'b0;
        check("par_clr", parity_out, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
